// File: rtl/cmp_pkg.sv
// Condition codes and helper functions shared by the branch compare pipeline.
// decode() maps the final (eq, lt) pair of an MSB-first compare onto the taken bit.
package cmp_pkg;

  typedef logic [2:0] cmp_op_t;

  localparam cmp_op_t CMP_EQ  = 3'd0;
  localparam cmp_op_t CMP_NE  = 3'd1;
  localparam cmp_op_t CMP_GTZ = 3'd2;
  localparam cmp_op_t CMP_LEZ = 3'd3;
  localparam cmp_op_t CMP_LTZ = 3'd4;
  localparam cmp_op_t CMP_GEZ = 3'd5;
  localparam cmp_op_t CMP_LT  = 3'd6;
  localparam cmp_op_t CMP_LTU = 3'd7;

  function automatic logic is_signed(input cmp_op_t op);
    return (op >= CMP_GTZ) && (op <= CMP_LT);
  endfunction

  function automatic logic uses_zero(input cmp_op_t op);
    return (op >= CMP_GTZ) && (op <= CMP_GEZ);
  endfunction

  function automatic logic decode(input cmp_op_t op, input logic eq, input logic lt);
    logic t;
    case (op)
      CMP_EQ:  t = eq;
      CMP_NE:  t = ~eq;
      CMP_GTZ: t = ~lt & ~eq;
      CMP_LEZ: t = lt | eq;
      CMP_GEZ: t = ~lt;
      default: t = lt;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// One chunk of an MSB-first magnitude compare; folds this chunk into the running eq/lt.
// invert_msb turns the unsigned chunk compare into a signed one for the top chunk.
module cmp_slice #(
  parameter int CW = 16
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          eq_in,
  input  logic          lt_in,
  input  logic          invert_msb,
  output logic          eq_out,
  output logic          lt_out
);

  logic [CW-1:0] a_m;
  logic [CW-1:0] b_m;

  always_comb begin
    a_m = a;
    b_m = b;
    a_m[CW-1] = a[CW-1] ^ invert_msb;
    b_m[CW-1] = b[CW-1] ^ invert_msb;
  end

  assign eq_out = eq_in & (a_m == b_m);
  assign lt_out = lt_in | (eq_in & (a_m < b_m));

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch-condition evaluator: STAGES chunked compare stages with valid/ready flow
// control, tag pass-through and flush. The last stage register is the output register.
module branch_cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] v_q, v_d, en, src_v;

  logic             src_eq  [STAGES];
  logic             src_lt  [STAGES];
  logic             inv     [STAGES];
  logic             eq_s    [STAGES];
  logic             lt_s    [STAGES];
  cmp_op_t          src_op  [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [TAG_W-1:0] src_tag [STAGES];

  logic             eq_q  [STAGES];
  logic             lt_q  [STAGES];
  cmp_op_t          op_q  [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [TAG_W-1:0] tag_q [STAGES];

  logic             taken_q;
  logic [TAG_W-1:0] out_tag_q;

  // A stage may load when some stage at or downstream of it is empty, or the output drains.
  always_comb begin
    logic e;
    en = '0;
    for (int k = 0; k < STAGES; k++) begin
      e = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!v_q[j]) e = 1'b1;
      end
      en[k] = e;
    end
  end

  assign in_ready = ~flush & en[0];

  always_comb begin
    v_d = (en & src_v) | (~en & v_q);
    if (flush) v_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else        v_q <= v_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign src_v[0]   = in_valid & in_ready;
        assign src_a[0]   = rs;
        assign src_b[0]   = uses_zero(op) ? '0 : rt;
        assign src_eq[0]  = 1'b1;
        assign src_lt[0]  = 1'b0;
        assign src_op[0]  = op;
        assign src_tag[0] = in_tag;
        assign inv[0]     = is_signed(op);
      end else begin : g_body
        assign src_v[gi]   = v_q[gi-1];
        assign src_a[gi]   = a_q[gi-1];
        assign src_b[gi]   = b_q[gi-1];
        assign src_eq[gi]  = eq_q[gi-1];
        assign src_lt[gi]  = lt_q[gi-1];
        assign src_op[gi]  = op_q[gi-1];
        assign src_tag[gi] = tag_q[gi-1];
        assign inv[gi]     = 1'b0;
      end

      cmp_slice #(.CW(CW)) u_slice (
        .a          (src_a[gi][WIDTH-1-gi*CW -: CW]),
        .b          (src_b[gi][WIDTH-1-gi*CW -: CW]),
        .eq_in      (src_eq[gi]),
        .lt_in      (src_lt[gi]),
        .invert_msb (inv[gi]),
        .eq_out     (eq_s[gi]),
        .lt_out     (lt_s[gi])
      );

      if (gi < LAST) begin : g_reg
        always_ff @(posedge clk) begin
          if (en[gi] && src_v[gi]) begin
            eq_q[gi]  <= eq_s[gi];
            lt_q[gi]  <= lt_s[gi];
            op_q[gi]  <= src_op[gi];
            a_q[gi]   <= src_a[gi];
            b_q[gi]   <= src_b[gi];
            tag_q[gi] <= src_tag[gi];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q   <= 1'b0;
      out_tag_q <= '0;
    end else if (en[LAST] && src_v[LAST]) begin
      taken_q   <= decode(src_op[LAST], eq_s[LAST], lt_s[LAST]);
      out_tag_q <= src_tag[LAST];
    end
  end

  assign out_valid = v_q[LAST];
  assign taken     = taken_q;
  assign out_tag   = out_tag_q;
  assign busy      = |v_q;

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Randomised scoreboard bench for branch_cmp_pipe: the driver pushes model results on accept,
// an independent monitor pops and compares every consumed output.
module tb_branch_cmp_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, taken, busy;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs, rt;
  logic [TAG_W-1:0] in_tag, out_tag;

  branch_cmp_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rt(rt), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .taken(taken), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit taken; bit [TAG_W-1:0] tag; } exp_t;
  exp_t exp_q[$];
  int   log_tag[$];
  int   log_cyc[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  always @(posedge clk) cyc <= cyc + 1;

  // Reference behaviour written straight from the condition definitions.
  function automatic bit ref_taken(input int op_i, input bit [31:0] a, input bit [31:0] b);
    int signed sa = a;
    int signed sb = b;
    case (op_i)
      0: return a == b;
      1: return a != b;
      2: return sa > 0;
      3: return sa <= 0;
      4: return sa < 0;
      5: return sa >= 0;
      6: return sa < sb;
      default: return a < b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: consumes whatever the DUT hands over and checks it against the scoreboard.
  always begin
    exp_t e;
    @(negedge clk);
    if (rst_n && out_valid && out_ready && !flush) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_output: got tag=%0d taken=%0d with empty scoreboard", out_tag, taken);
      end else begin
        e = exp_q.pop_front();
        if (taken !== e.taken || out_tag !== e.tag) begin
          n_mis++;
          $display("FAIL result: got tag=%0d taken=%0d expected tag=%0d taken=%0d",
                   out_tag, taken, e.tag, e.taken);
        end else begin
          $display("out cycle=%0d tag=%0d taken=%0d", cyc, out_tag, taken);
        end
      end
      log_tag.push_back(int'(out_tag));
      log_cyc.push_back(cyc);
    end
  end

  // Presents one request (caller is just after a rising edge) and holds it until accepted.
  task automatic send(input int op_i, input bit [31:0] a, input bit [31:0] b, input int tag);
    bit ok = 0;
    exp_t e;
    in_valid = 1'b1; op = 3'(op_i); rs = a; rt = b; in_tag = TAG_W'(tag);
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        e.taken = ref_taken(op_i, a, b);
        e.tag   = TAG_W'(tag);
        exp_q.push_back(e);
      end
      sync();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  // Single request with an exact latency check.
  task automatic send_lat(input int op_i, input bit [31:0] a, input bit [31:0] b, input int tag);
    exp_t e;
    in_valid = 1'b1; op = 3'(op_i); rs = a; rt = b; in_tag = TAG_W'(tag);
    @(negedge clk);
    chk("lat_in_ready", in_ready, 1);
    e.taken = ref_taken(op_i, a, b);
    e.tag   = TAG_W'(tag);
    exp_q.push_back(e);
    sync();
    in_valid = 1'b0;
    for (int j = 1; j < STAGES; j++) begin
      @(negedge clk);
      chk("lat_early_valid", out_valid, 0);
    end
    @(negedge clk);
    chk("lat_out_valid", out_valid, 1);
    sync();
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !out_valid) done = 1;
    end
    chk("drain_complete", done, 1);
    sync();
  endtask

  function automatic bit [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int acc;
    bit [31:0] a, b;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; op = '0; rs = '0; rt = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_taken", taken, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    sync();

    // Equality with latency, then NE on the same operands
    send_lat(0, 32'h1234_5678, 32'h1234_5678, 1);
    send_lat(1, 32'h1234_5678, 32'h1234_5678, 2);

    // Signed vs unsigned and the zero boundaries
    send(6, 32'hFFFF_FFFF, 32'h0000_0001, 3);
    send(7, 32'hFFFF_FFFF, 32'h0000_0001, 4);
    for (int o = 2; o <= 5; o++) send(o, 32'hFFFF_FFFF, 32'h0000_0001, 4 + o);
    for (int o = 2; o <= 5; o++) send(o, 32'h0000_0000, 32'hDEAD_BEEF, 8 + o);
    send(4, 32'h8000_0000, 0, 14);
    send(2, 32'h7FFF_FFFF, 0, 15);
    drain();

    // Back-to-back tags 0..7, one result per cycle
    log_tag.delete(); log_cyc.delete();
    for (int t = 0; t < 8; t++) send($urandom_range(0, 7), $urandom, $urandom, t);
    drain();
    chk("b2b_count", log_tag.size(), 8);
    for (int i = 0; i < log_tag.size() && i < 8; i++) begin
      chk("b2b_tag", log_tag[i], i);
      if (i > 0) chk("b2b_spacing", log_cyc[i] - log_cyc[i-1], 1);
    end

    // Stall: keep offering requests with the consumer blocked
    rdy_mode = 2;
    sync(); sync();
    acc = 0;
    in_valid = 1'b1; op = 3'd6; rs = $urandom; rt = $urandom; in_tag = 5'd20;
    for (int c = 0; c < 5; c++) begin
      exp_t e;
      @(negedge clk);
      if (in_ready) begin
        e.taken = ref_taken(int'(op), rs, rt);
        e.tag   = in_tag;
        exp_q.push_back(e);
        acc++;
      end
      sync();
      if (e.tag == in_tag && acc > 0) begin
        op = 3'($urandom_range(0, 7)); rs = $urandom; rt = $urandom; in_tag = in_tag + 1'b1;
      end
    end
    @(negedge clk);
    chk("stall_in_ready_low", in_ready, 0);
    chk("stall_accepts", (acc >= STAGES && acc <= STAGES + 1), 1);
    sync();
    in_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // Random traffic with random back-pressure
    rdy_mode = 1;
    for (int n = 0; n < 150; n++) begin
      a = pick_operand();
      b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      if ($urandom_range(0, 4) == 0) sync();
      send($urandom_range(0, 7), a, b, n);
    end
    rdy_mode = 0;
    drain();

    // Flush with the pipe full plus a new request
    rdy_mode = 2;
    sync(); sync();
    for (int t = 0; t < STAGES; t++) send(1, t, 32'h55, 24 + t);
    flush = 1'b1;
    in_valid = 1'b1; op = 3'd0; rs = 0; rt = 0; in_tag = 5'h1F;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    chk("flush_pre_busy", busy, 1);
    sync();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    rdy_mode = 0;
    repeat (10) sync();

    // Asynchronous reset mid-stream
    rdy_mode = 2;
    sync(); sync();
    send(1, 32'h1, 32'h2, 5'h1F);
    send(3, 32'h1, 32'h0, 5'h1E);
    @(negedge clk);
    chk("arst_pre_valid", out_valid, 1);
    chk("arst_pre_taken", taken, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_taken", taken, 0);
    chk("arst_out_tag", out_tag, 0);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    sync();
    send(7, 32'h1, 32'hFFFF_FFFF, 9);
    drain();
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
